fc_layer_sched: RTL and testbench

//  Sequencer for the 2-input fully-connected MAC (36 accumulate cycles + 1 bias cycle, sticky ready).

---
 rtl/fc_layer_sched_pkg.sv | 33 +++
 rtl/fc_layer_sched_if.sv | 55 +++++
 rtl/fc_layer_sched_argmax.sv | 57 +++++
 rtl/fc_layer_sched.sv | 169 ++++++++++++++++
 tb/tb_fc_layer_sched.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_sched_pkg.sv
// =============================================================================
// Module : fc_layer_sched_pkg
// Brief  : Shared defaults, FSM encoding and address-width helper for the
//          fully-connected layer scheduler.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package fc_layer_sched_pkg;

    localparam int c_DEF_BIT_WIDTH = 8;
    localparam int c_DEF_OUT_WIDTH = 32;
    localparam int c_DEF_N_PAIRS   = 36;
    localparam int c_DEF_N_OUT     = 10;
    localparam int c_DEF_RELU      = 0;
    localparam int c_DEF_TIMEOUT   = 40;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Keeps single-entry ranges at one address bit instead of zero.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_layer_sched_if.sv
// =============================================================================
// Module : fc_layer_sched_if
// Brief  : Control, MAC and output-buffer signals of the layer scheduler.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

interface fc_layer_sched_if
    import fc_layer_sched_pkg::*;
#(
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH,
    parameter int N_PAIRS   = c_DEF_N_PAIRS,
    parameter int N_OUT     = c_DEF_N_OUT
) ();

    localparam int c_IN_AW = addr_width(N_PAIRS);
    localparam int c_W_AW  = addr_width(N_OUT * N_PAIRS);
    localparam int c_N_AW  = addr_width(N_OUT);

    logic                        start_i;
    logic                        busy_o;
    logic                        done_o;
    logic                        err_o;
    logic [c_IN_AW-1:0]          in_addr_o;
    logic [c_W_AW-1:0]           w_addr_o;
    logic [c_N_AW-1:0]           b_addr_o;
    logic                        mac_rst_n_o;
    logic                        mac_en_o;
    logic                        mac_ready_i;
    logic signed [OUT_WIDTH-1:0] mac_value_i;
    logic                        out_wr_en_o;
    logic [c_N_AW-1:0]           out_addr_o;
    logic signed [OUT_WIDTH-1:0] out_data_o;
    logic [c_N_AW-1:0]           class_idx_o;
    logic signed [OUT_WIDTH-1:0] class_val_o;

    // Scheduler side.
    modport master (
        input  start_i, mac_ready_i, mac_value_i,
        output busy_o, done_o, err_o, in_addr_o, w_addr_o, b_addr_o,
               mac_rst_n_o, mac_en_o, out_wr_en_o, out_addr_o, out_data_o,
               class_idx_o, class_val_o
    );

    // Host / MAC / memory side.
    modport slave (
        output start_i, mac_ready_i, mac_value_i,
        input  busy_o, done_o, err_o, in_addr_o, w_addr_o, b_addr_o,
               mac_rst_n_o, mac_en_o, out_wr_en_o, out_addr_o, out_data_o,
               class_idx_o, class_val_o
    );

endinterface

`default_nettype wire

// File: rtl/fc_layer_sched_argmax.sv
// =============================================================================
// Module : fc_layer_sched_argmax
// Brief  : Running signed maximum and its index; strict compare keeps the
//          earliest index on ties.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fc_layer_sched_argmax #(
    parameter int OUT_WIDTH = 32,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        upd_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic signed [OUT_WIDTH-1:0] val_i,
    output logic [IDX_W-1:0]            idx_o,
    output logic signed [OUT_WIDTH-1:0] val_o
);

    localparam logic signed [OUT_WIDTH-1:0] c_MOST_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [OUT_WIDTH-1:0] val_q, val_d;
    logic                        w_take;

    always_comb begin
        w_take = upd_i && (val_i > val_q);
        idx_d  = idx_q;
        val_d  = val_q;
        if (clr_i) begin
            idx_d = '0;
            val_d = c_MOST_NEG;
        end else if (w_take) begin
            idx_d = idx_i;
            val_d = val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            val_q <= '0;
        end else begin
            idx_q <= idx_d;
            val_q <= val_d;
        end
    end

    assign idx_o = idx_q;
    assign val_o = val_q;

endmodule

`default_nettype wire

// File: rtl/fc_layer_sched.sv
// =============================================================================
// Module : fc_layer_sched
// Brief  : Walks the neurons of a 2-input FC layer through the MAC, stores
//          each result (optional ReLU) and tracks the layer argmax.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fc_layer_sched
    import fc_layer_sched_pkg::*;
#(
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH,
    parameter int N_PAIRS   = c_DEF_N_PAIRS,
    parameter int N_OUT     = c_DEF_N_OUT,
    parameter int RELU      = c_DEF_RELU,
    parameter int TIMEOUT   = c_DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    fc_layer_sched_if.master bus
);

    localparam int c_IN_AW  = addr_width(N_PAIRS);
    localparam int c_W_AW   = addr_width(N_OUT * N_PAIRS);
    localparam int c_N_AW   = addr_width(N_OUT);
    localparam int c_RUN_W  = addr_width(TIMEOUT + 1);

    localparam logic [c_IN_AW-1:0] c_LAST_PAIR   = c_IN_AW'(N_PAIRS - 1);
    localparam logic [c_IN_AW-1:0] c_IN_ONE      = c_IN_AW'(1);
    localparam logic [c_W_AW-1:0]  c_W_ONE       = c_W_AW'(1);
    localparam logic [c_W_AW-1:0]  c_W_STRIDE    = c_W_AW'(N_PAIRS);
    localparam logic [c_N_AW-1:0]  c_N_ONE       = c_N_AW'(1);
    localparam logic [c_N_AW-1:0]  c_LAST_NEURON = c_N_AW'(N_OUT - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE     = c_RUN_W'(1);
    localparam logic [c_RUN_W-1:0] c_RUN_LAST    = c_RUN_W'(TIMEOUT - 1);

    state_t                      state_q;
    logic [c_N_AW-1:0]           neuron_q;
    logic [c_IN_AW-1:0]          in_addr_q;
    logic [c_W_AW-1:0]           w_addr_q;
    logic [c_W_AW-1:0]           w_base_q;
    logic [c_RUN_W-1:0]          run_cnt_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;
    logic                        mac_rst_n_q;
    logic                        out_wr_en_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;

    logic                        w_addr_adv;
    logic                        w_am_clr;
    logic                        w_am_upd;
    logic signed [OUT_WIDTH-1:0] w_store_val;

    if (RELU != 0) begin : g_relu
        assign w_store_val = bus.mac_value_i[OUT_WIDTH-1] ? '0 : bus.mac_value_i;
    end else begin : g_raw
        assign w_store_val = bus.mac_value_i;
    end

    // Addresses run one pair ahead of the MAC and park on the last pair.
    assign w_addr_adv = ((state_q == S_CLR) || (state_q == S_RUN)) && (in_addr_q != c_LAST_PAIR);
    assign w_am_clr   = (state_q == S_IDLE) && bus.start_i;
    assign w_am_upd   = (state_q == S_RUN) && bus.mac_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neuron_q    <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            w_base_q    <= '0;
            run_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mac_rst_n_q <= 1'b0;
            out_wr_en_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            out_wr_en_q <= 1'b0;
            if (w_addr_adv) begin
                in_addr_q <= in_addr_q + c_IN_ONE;
                w_addr_q  <= w_addr_q + c_W_ONE;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_q     <= S_CLR;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        neuron_q    <= '0;
                        w_base_q    <= '0;
                        in_addr_q   <= '0;
                        w_addr_q    <= '0;
                        mac_rst_n_q <= 1'b0;
                    end
                end
                S_CLR: begin
                    state_q     <= S_RUN;
                    mac_rst_n_q <= 1'b1;
                    run_cnt_q   <= '0;
                end
                S_RUN: begin
                    if (bus.mac_ready_i) begin
                        state_q     <= S_STORE;
                        out_wr_en_q <= 1'b1;
                        out_data_q  <= w_store_val;
                    end else if (run_cnt_q == c_RUN_LAST) begin
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        run_cnt_q <= run_cnt_q + c_RUN_ONE;
                    end
                end
                S_STORE: begin
                    if (neuron_q == c_LAST_NEURON) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_CLR;
                        neuron_q    <= neuron_q + c_N_ONE;
                        w_base_q    <= w_base_q + c_W_STRIDE;
                        w_addr_q    <= w_base_q + c_W_STRIDE;
                        in_addr_q   <= '0;
                        mac_rst_n_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fc_layer_sched_argmax #(
        .OUT_WIDTH (OUT_WIDTH),
        .IDX_W     (c_N_AW)
    ) u_argmax (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_am_clr),
        .upd_i (w_am_upd),
        .idx_i (neuron_q),
        .val_i (bus.mac_value_i),
        .idx_o (bus.class_idx_o),
        .val_o (bus.class_val_o)
    );

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.in_addr_o   = in_addr_q;
    assign bus.w_addr_o    = w_addr_q;
    assign bus.b_addr_o    = neuron_q;
    // The MAC must see reset for as long as the scheduler is held in reset.
    assign bus.mac_rst_n_o = mac_rst_n_q & ~rst;
    assign bus.mac_en_o    = (state_q == S_RUN) & ~bus.mac_ready_i;
    assign bus.out_wr_en_o = out_wr_en_q;
    assign bus.out_addr_o  = neuron_q;
    assign bus.out_data_o  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_sched.sv
// =============================================================================
// Module : tb_fc_layer_sched
// Brief  : Directed bench; instance 0 stores raw results, instance 1 ReLU.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_fc_layer_sched;
    import fc_layer_sched_pkg::*;

    localparam int c_NP = 36;
    localparam int c_NO = 10;
    localparam int c_BW = c_DEF_BIT_WIDTH;

    logic clk;
    logic rst;
    logic start;
    logic force_nordy;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   restart_at;
    int   rst_at;
    int   exp_raw [c_NO];

    logic signed [c_BW-1:0] in0_mem [c_NP];
    logic signed [c_BW-1:0] in1_mem [c_NP];
    logic signed [c_BW-1:0] w0_mem  [c_NO*c_NP];
    logic signed [c_BW-1:0] w1_mem  [c_NO*c_NP];
    logic signed [c_BW-1:0] b_mem   [c_NO];

    logic              busy_w  [2];
    logic              done_w  [2];
    logic              err_w   [2];
    logic              wr_w    [2];
    logic              mrst_w  [2];
    logic              men_w   [2];
    logic [5:0]        inad_w  [2];
    logic [8:0]        wad_w   [2];
    logic [3:0]        bad_w   [2];
    logic [3:0]        oad_w   [2];
    logic [3:0]        cidx_w  [2];
    logic signed [31:0] odat_w [2];
    logic signed [31:0] cval_w [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fc_layer_sched_if #(.OUT_WIDTH(32), .N_PAIRS(c_NP), .N_OUT(c_NO)) bus ();

        logic signed [c_BW-1:0] in0_q, in1_q, w0_q, w1_q, b_q;
        logic signed [31:0]     acc_q;
        logic [5:0]             cnt_q;
        logic                   rdy_q;

        fc_layer_sched #(
            .OUT_WIDTH (32),
            .N_PAIRS   (c_NP),
            .N_OUT     (c_NO),
            .RELU      (g),
            .TIMEOUT   (40)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Sync-read memories plus a 36+1 cycle MAC with sticky ready.
        always_ff @(posedge clk) begin
            in0_q <= in0_mem[bus.in_addr_o];
            in1_q <= in1_mem[bus.in_addr_o];
            w0_q  <= w0_mem[bus.w_addr_o];
            w1_q  <= w1_mem[bus.w_addr_o];
            b_q   <= b_mem[bus.b_addr_o];
            if (!bus.mac_rst_n_o) begin
                acc_q <= '0;
                cnt_q <= '0;
                rdy_q <= 1'b0;
            end else if (bus.mac_en_o && !rdy_q) begin
                if (cnt_q < 6'(c_NP)) begin
                    acc_q <= acc_q + in0_q * w0_q + in1_q * w1_q;
                    cnt_q <= cnt_q + 6'd1;
                end else begin
                    acc_q <= acc_q + b_q;
                    rdy_q <= 1'b1;
                end
            end
        end

        assign bus.start_i     = start;
        assign bus.mac_ready_i = rdy_q & ~force_nordy;
        assign bus.mac_value_i = acc_q;

        assign busy_w[g] = bus.busy_o;
        assign done_w[g] = bus.done_o;
        assign err_w[g]  = bus.err_o;
        assign wr_w[g]   = bus.out_wr_en_o;
        assign mrst_w[g] = bus.mac_rst_n_o;
        assign men_w[g]  = bus.mac_en_o;
        assign inad_w[g] = bus.in_addr_o;
        assign wad_w[g]  = bus.w_addr_o;
        assign bad_w[g]  = bus.b_addr_o;
        assign oad_w[g]  = bus.out_addr_o;
        assign cidx_w[g] = bus.class_idx_o;
        assign odat_w[g] = bus.out_data_o;
        assign cval_w[g] = bus.class_val_o;
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_of(input int inst, input int n);
        if (inst == 1 && exp_raw[n] < 0) return 0;
        return exp_raw[n];
    endfunction

    task automatic fill(input int inv, input int wv, input int ev);
        for (int i = 0; i < c_NP; i++) begin
            in0_mem[i] = c_BW'(inv);
            in1_mem[i] = c_BW'(inv);
        end
        for (int i = 0; i < c_NO * c_NP; i++) begin
            w0_mem[i] = c_BW'(wv);
            w1_mem[i] = c_BW'(wv);
        end
        for (int i = 0; i < c_NO; i++) begin
            b_mem[i]   = '0;
            exp_raw[i] = ev;
        end
    endtask

    // exp_done < 0 means no done pulse is expected (aborted by rst).
    task automatic run_layer(input int exp_writes, input int exp_done, input int exp_err);
        int t0;
        int rel;
        int nw [2];
        bit seen;
        nw[0] = 0;
        nw[1] = 0;
        seen  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0  = cyc - 1;
        rel = cyc - t0;
        chk("busy_c1", busy_w[0], 1);
        chk("err_c1", err_w[0], 0);
        chk("mrst_c1", mrst_w[0], 0);
        chk("waddr_c1", wad_w[0], 0);
        while (!seen && rel < 460) begin
            @(negedge clk);
            rel   = cyc - t0;
            start = (rel == restart_at);
            if (rel == rst_at) rst = 1'b1;
            else if (rel == rst_at + 3) rst = 1'b0;
            if (rel == rst_at + 1) begin
                chk("rst_busy", busy_w[0], 0);
                chk("rst_mrst", mrst_w[0], 0);
            end
            if (rel == 2 && exp_writes > 0) begin
                chk("inaddr_c2", inad_w[0], 1);
                chk("waddr_c2", wad_w[0], 1);
                chk("men_c2", men_w[0], 1);
            end
            if (rel == 38 && exp_writes > 0) begin
                chk("inaddr_sat", inad_w[0], 35);
                chk("waddr_sat", wad_w[0], 35);
                chk("men_c38", men_w[0], 1);
            end
            if (rel == 39 && exp_writes > 0) chk("men_rdy", men_w[0], 0);
            if (rel == 41 && exp_writes > 1) begin
                chk("waddr_n1", wad_w[0], 36);
                chk("baddr_n1", bad_w[0], 1);
                chk("mrst_n1", mrst_w[0], 0);
            end
            for (int k = 0; k < 2; k++) begin
                if (wr_w[k]) begin
                    chk("wr_cyc", rel, 40 * (nw[k] + 1));
                    chk("wr_addr", oad_w[k], nw[k]);
                    if (nw[k] < c_NO) chk("wr_data", odat_w[k], exp_of(k, nw[k]));
                    nw[k]++;
                end
            end
            if (done_w[0]) begin
                seen = 1'b1;
                chk("done_cyc", rel, exp_done);
            end
        end
        chk("done_seen", seen, (exp_done >= 0) ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            chk("n_writes", nw[k], exp_writes);
            chk("err_end", err_w[k], exp_err);
        end
        @(negedge clk);
        chk("busy_end", busy_w[0], 0);
        chk("done_pulse", done_w[0], 0);
        restart_at = -100;
        rst_at     = -100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start       = 1'b0;
        rst         = 1'b1;
        force_nordy = 1'b0;
        restart_at  = -100;
        rst_at      = -100;
        fill(1, 1, 72);
        repeat (3) @(negedge clk);
        chk("rst_busy0", busy_w[0], 0);
        chk("rst_done0", done_w[0], 0);
        chk("rst_err0", err_w[0], 0);
        chk("rst_wr0", wr_w[0], 0);
        chk("rst_mrst0", mrst_w[0], 0);
        chk("rst_men0", men_w[0], 0);
        chk("rst_inaddr0", inad_w[0], 0);
        chk("rst_waddr0", wad_w[0], 0);
        chk("rst_baddr0", bad_w[0], 0);
        chk("rst_cidx0", cidx_w[0], 0);
        chk("rst_cval0", cval_w[0], 0);
        rst = 1'b0;

        // Uniform data: every neuron 36*2 = 72, ties resolve to neuron 0.
        run_layer(10, 401, 0);
        chk("t1_cidx", cidx_w[0], 0);
        chk("t1_cval", cval_w[0], 72);

        b_mem[7]   = 8'sd5;
        exp_raw[7] = 77;
        run_layer(10, 401, 0);
        chk("t2_cidx", cidx_w[0], 7);
        chk("t2_cval", cval_w[0], 77);

        b_mem[2]   = 8'sd5;
        exp_raw[2] = 77;
        run_layer(10, 401, 0);
        chk("t2_tie_cidx", cidx_w[0], 2);
        chk("t2_tie_cval", cval_w[0], 77);

        // Negative results: raw -72, ReLU instance stores 0, argmax stays pre-ReLU.
        fill(1, -1, -72);
        run_layer(10, 401, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t3_cidx", cidx_w[k], 0);
            chk("t3_cval", cval_w[k], -72);
        end

        fill(1, 1, 72);
        force_nordy = 1'b1;
        run_layer(0, 42, 1);
        force_nordy = 1'b0;
        run_layer(10, 401, 0);

        rst_at = 100;
        run_layer(2, -1, 0);
        run_layer(10, 401, 0);

        restart_at = 50;
        run_layer(10, 401, 0);
        chk("t6_cval", cval_w[0], 72);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
